// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - program load / run / stop sequencer for the 5-stage RISC-V core
module cpu_run_ctrl #(
  parameter int IMEM_ADDR_W = 9,
  parameter int DMEM_ADDR_W = 10,
  parameter int CYCLE_W     = 32
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 start,
  input  logic [IMEM_ADDR_W:0] imem_len,
  input  logic [DMEM_ADDR_W:0] dmem_len,
  input  logic [CYCLE_W-1:0]   run_cycles,
  input  logic                 s_valid,
  input  logic [63:0]          s_data,
  output logic                 s_ready,
  output logic [63:0]          addr_ext,
  output logic                 wen_ext,
  output logic [31:0]          wdata_ext,
  output logic [63:0]          addr_ext_2,
  output logic                 wen_ext_2,
  output logic [63:0]          wdata_ext_2,
  output logic                 cpu_enable,
  output logic                 busy,
  output logic                 done,
  output logic [CYCLE_W-1:0]   cycle_count
);

  localparam int IDX_W = ((IMEM_ADDR_W > DMEM_ADDR_W) ? IMEM_ADDR_W : DMEM_ADDR_W) + 1;
  localparam logic [IMEM_ADDR_W:0] IMEM_DEPTH = {1'b1, {IMEM_ADDR_W{1'b0}}};
  localparam logic [DMEM_ADDR_W:0] DMEM_DEPTH = {1'b1, {DMEM_ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD_I, ST_LOAD_D, ST_SETTLE, ST_RUN, ST_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   imem_cnt, dmem_cnt, idx;
  logic [IDX_W-1:0]   imem_len_c, dmem_len_c;
  logic [CYCLE_W-1:0] run_q;
  logic               start_ok, hs, last_i, last_d, run_last;

  // Lengths are clamped to memory depth so the index can never wrap an address.
  always_comb begin
    imem_len_c = (imem_len > IMEM_DEPTH) ? IDX_W'(IMEM_DEPTH) : IDX_W'(imem_len);
    dmem_len_c = (dmem_len > DMEM_DEPTH) ? IDX_W'(DMEM_DEPTH) : IDX_W'(dmem_len);
  end

  assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign hs       = s_valid && s_ready;
  assign last_i   = (idx + IDX_W'(1)) == imem_cnt;
  assign last_d   = (idx + IDX_W'(1)) == dmem_cnt;
  assign run_last = (cycle_count + CYCLE_W'(1)) == run_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (imem_len_c != '0)      state_nxt = ST_LOAD_I;
          else if (dmem_len_c != '0) state_nxt = ST_LOAD_D;
          else                       state_nxt = ST_SETTLE;
        end
      end
      ST_LOAD_I: if (hs && last_i) state_nxt = (dmem_cnt != '0) ? ST_LOAD_D : ST_SETTLE;
      ST_LOAD_D: if (hs && last_d) state_nxt = ST_SETTLE;
      ST_SETTLE: state_nxt = (run_q != '0) ? ST_RUN : ST_DONE;
      ST_RUN:    if (run_last) state_nxt = ST_DONE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready    = ((state == ST_LOAD_I) && (idx < imem_cnt)) ||
                 ((state == ST_LOAD_D) && (idx < dmem_cnt));
    cpu_enable = (state == ST_RUN);
    done       = (state == ST_DONE);
    busy       = (state == ST_LOAD_I) || (state == ST_LOAD_D) ||
                 (state == ST_SETTLE) || (state == ST_RUN);
  end

  // Write ports are registered: one pulse the cycle after each accepted word.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      imem_cnt    <= '0;
      dmem_cnt    <= '0;
      run_q       <= '0;
      idx         <= '0;
      cycle_count <= '0;
      addr_ext    <= '0;
      wen_ext     <= 1'b0;
      wdata_ext   <= '0;
      addr_ext_2  <= '0;
      wen_ext_2   <= 1'b0;
      wdata_ext_2 <= '0;
    end else begin
      wen_ext   <= 1'b0;
      wen_ext_2 <= 1'b0;
      if (start_ok) begin
        imem_cnt    <= imem_len_c;
        dmem_cnt    <= dmem_len_c;
        run_q       <= run_cycles;
        idx         <= '0;
        cycle_count <= '0;
      end
      if ((state == ST_LOAD_I) && hs) begin
        wen_ext   <= 1'b1;
        addr_ext  <= 64'({idx, 2'b00});
        wdata_ext <= s_data[31:0];
        idx       <= last_i ? '0 : idx + IDX_W'(1);
      end
      if ((state == ST_LOAD_D) && hs) begin
        wen_ext_2   <= 1'b1;
        addr_ext_2  <= 64'({idx, 3'b000});
        wdata_ext_2 <= s_data;
        idx         <= last_d ? '0 : idx + IDX_W'(1);
      end
      if (state == ST_RUN) cycle_count <= cycle_count + CYCLE_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - scoreboard bench for cpu_run_ctrl with randomized stream stimulus
module tb_cpu_run_ctrl;

  localparam int IW = 9;
  localparam int DW = 10;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          arst_n = 1'b1;
  logic          start = 1'b0;
  logic [IW:0]   imem_len = '0;
  logic [DW:0]   dmem_len = '0;
  logic [CW-1:0] run_cycles = '0;
  logic          s_valid = 1'b0;
  logic [63:0]   s_data = '0;
  logic          s_ready, wen_ext, wen_ext_2, cpu_enable, busy, done;
  logic [63:0]   addr_ext, addr_ext_2, wdata_ext_2;
  logic [31:0]   wdata_ext;
  logic [CW-1:0] cycle_count;

  cpu_run_ctrl #(.IMEM_ADDR_W(IW), .DMEM_ADDR_W(DW), .CYCLE_W(CW)) dut (
    .clk(clk), .arst_n(arst_n), .start(start), .imem_len(imem_len), .dmem_len(dmem_len),
    .run_cycles(run_cycles), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .wdata_ext_2(wdata_ext_2),
    .cpu_enable(cpu_enable), .busy(busy), .done(done), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    int          cyc;
  } wr_t;

  wr_t iq[$];
  wr_t dq[$];
  int  cyc = 0;
  int  en_cnt = 0;
  int  total_n = 0;
  int  bad_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every write pulse must match the oldest pending accepted word.
  always @(negedge clk) begin
    wr_t e;
    if (!arst_n) begin
      iq.delete();
      dq.delete();
    end else begin
      if (cpu_enable) begin
        en_cnt++;
        chk("no_write_in_run", 64'({wen_ext, wen_ext_2}), 64'(0));
      end
      if (wen_ext) begin
        if (iq.size() == 0) begin
          total_n++; bad_n++;
          $display("FAIL imem_extra_pulse: got pulse at %0h want none", addr_ext);
        end else begin
          e = iq.pop_front();
          chk("imem_addr", addr_ext, e.addr);
          chk("imem_data", 64'(wdata_ext), 64'(e.data[31:0]));
          chk("imem_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (wen_ext_2) begin
        if (dq.size() == 0) begin
          total_n++; bad_n++;
          $display("FAIL dmem_extra_pulse: got pulse at %0h want none", addr_ext_2);
        end else begin
          e = dq.pop_front();
          chk("dmem_addr", addr_ext_2, e.addr);
          chk("dmem_data", wdata_ext_2, e.data);
          chk("dmem_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, "_flags"}, 64'({s_ready, wen_ext, wen_ext_2, cpu_enable, busy, done}), 64'(0));
    chk({nm, "_addr_i"}, addr_ext, 64'(0));
    chk({nm, "_addr_d"}, addr_ext_2, 64'(0));
    chk({nm, "_wdata"}, {32'b0, wdata_ext} | wdata_ext_2, 64'(0));
    chk({nm, "_cycles"}, 64'(cycle_count), 64'(0));
  endtask

  // Issue start, then feed words; abort_after >= 0 resets after that many transfers.
  task automatic run_op(input int il, input int dl, input int rc, input int vprob,
                        input bit poke, input int abort_after);
    int  ilc, dlc, tot, k, budget, en0;
    wr_t w;
    ilc = (il > 512) ? 512 : il;
    dlc = (dl > 1024) ? 1024 : dl;
    tot = ilc + dlc;
    @(negedge clk);
    start = 1'b1;
    imem_len = (IW+1)'(il);
    dmem_len = (DW+1)'(dl);
    run_cycles = CW'(rc);
    @(negedge clk);
    start = 1'b0;
    imem_len = (IW+1)'($urandom);
    dmem_len = (DW+1)'($urandom);
    run_cycles = $urandom;
    en0 = en_cnt;
    chk("start_done_low", 64'(done), 64'(0));
    chk("start_cycles_clear", 64'(cycle_count), 64'(0));
    chk("start_busy", 64'(busy), 64'(1));
    k = 0;
    budget = tot * 40 + 50;
    while (k < tot && budget > 0) begin
      if (k == abort_after) begin
        s_valid = 1'b0;
        #2 arst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("held_reset");
        arst_n = 1'b1;
        return;
      end
      chk("s_ready_load", 64'(s_ready), 64'(1));
      s_valid = ($urandom_range(99) < vprob);
      s_data = {$urandom, $urandom};
      if (s_valid) begin
        w.data = s_data;
        w.cyc = cyc + 1;
        if (k < ilc) begin
          w.addr = 64'(4 * k);
          iq.push_back(w);
        end else begin
          w.addr = 64'(8 * (k - ilc));
          dq.push_back(w);
        end
        k++;
      end
      @(negedge clk);
      budget--;
    end
    s_valid = 1'b0;
    if (k < tot) begin
      total_n++; bad_n++;
      $display("FAIL load_timeout: got %0d words want %0d", k, tot);
    end
    chk("settle_ready", 64'(s_ready), 64'(0));
    chk("settle_enable", 64'(cpu_enable), 64'(0));
    chk("settle_busy_done", 64'({busy, done}), 64'(2));
    for (int i = 0; i < rc; i++) begin
      @(negedge clk);
      chk("run_enable", 64'(cpu_enable), 64'(1));
      chk("run_count", 64'(cycle_count), 64'(i));
      start = (poke && i == 0);
    end
    start = 1'b0;
    @(negedge clk);
    chk("done_flags", 64'({done, busy, cpu_enable}), 64'(4));
    chk("done_count", 64'(cycle_count), 64'(rc));
    chk("enable_cycles", 64'(en_cnt - en0), 64'(rc));
    chk("queues_drained", 64'(iq.size() + dq.size()), 64'(0));
  endtask

  initial begin
    #1 arst_n = 1'b0;
    #2 chk_all_zero("reset_state");
    @(negedge clk);
    arst_n = 1'b1;
    run_op(3, 2, 5, 100, 1'b0, -1);
    run_op(3, 2, 5, 50, 1'b0, -1);
    run_op(0, 0, 0, 100, 1'b0, -1);
    run_op(2, 1, 6, 70, 1'b1, -1);
    run_op(1, 1, 2, 100, 1'b0, -1);
    run_op(4, 8, 3, 100, 1'b0, 7);
    run_op(2, 2, 3, 80, 1'b0, -1);
    run_op(512, 0, 1, 100, 1'b0, -1);
    run_op(600, 3, 2, 90, 1'b0, -1);
    run_op(0, 4, 1, 60, 1'b0, -1);
    for (int n = 0; n < 10; n++)
      run_op(int'($urandom_range(20)), int'($urandom_range(20)), int'($urandom_range(15)),
             int'($urandom_range(100, 30)), 1'($urandom_range(1)), -1);
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
